// File: rtl/add_sub_pipe.sv
// add_sub_pipe -- slice-pipelined adder/subtractor with carry/borrow-in
// and ready/valid flow control.
//
// Each of the STAGES stages adds one WIDTH/STAGES-bit slice. It passes the
// slice carry and the still-unprocessed upper operand bits to the next stage.
// The last stage registers the full result and the C/V/Z/N flags.
//
// Optional feature: define ADD_SUB_PIPE_SAT_EN to enable signed saturation.
// A transaction with sat=1 that overflows returns the signed extreme.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/op presented      in_ready  block can accept (~stall)
//   a, b       WIDTH-bit operands         op        00 ADD 01 SUB 10 ADC 11 SBB
//   cin        carry-in (ADC) / borrow-in (SBB)
//   sat        saturation request (used only with ADD_SUB_PIPE_SAT_EN)
//   out_valid  result valid               out_ready downstream accepts
//   s          result                     flag_c/v/z/n carry, overflow, zero, negative
module add_sub_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage registers. r_b holds the already-conditioned operand (b or ~b).
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_cy;
  logic              r_v;
  logic              r_z;
  logic              r_n;
`ifdef ADD_SUB_PIPE_SAT_EN
  logic [STAGES-1:0] r_sat;
  logic [STAGES-1:0] w_sat_in;
`endif

  // Stage inputs and per-stage slice results.
  logic [WIDTH-1:0]  w_a_in   [STAGES];
  logic [WIDTH-1:0]  w_b_in   [STAGES];
  logic [WIDTH-1:0]  w_s_in   [STAGES];
  logic [WIDTH-1:0]  w_s_nxt  [STAGES];
  logic [SW:0]       w_sum    [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_vld_in;
  logic              w_c0;
  logic              w_stall;
  logic              w_cmsb;
  logic              w_ovf;
  logic [WIDTH-1:0]  w_fin;

  assign w_stall   = r_vld[LAST] & ~out_ready;
  assign in_ready  = ~w_stall;
  assign out_valid = r_vld[LAST];
  assign s         = r_s[LAST];
  assign flag_c    = r_cy[LAST];
  assign flag_v    = r_v;
  assign flag_z    = r_z;
  assign flag_n    = r_n;

  // Decode op into initial carry, then chain the slice adders through the stages.
  always_comb begin
    case (op)
      2'b00:   w_c0 = 1'b0;
      2'b01:   w_c0 = 1'b1;
      2'b10:   w_c0 = cin;
      2'b11:   w_c0 = ~cin;
      default: w_c0 = 1'b0;
    endcase
    w_a_in[0]   = a;
    w_b_in[0]   = op[0] ? ~b : b;
    w_s_in[0]   = {WIDTH{1'b0}};
    w_c_in[0]   = w_c0;
    w_vld_in[0] = in_valid;
`ifdef ADD_SUB_PIPE_SAT_EN
    w_sat_in[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k]   = r_a[k-1];
      w_b_in[k]   = r_b[k-1];
      w_s_in[k]   = r_s[k-1];
      w_c_in[k]   = r_cy[k-1];
      w_vld_in[k] = r_vld[k-1];
`ifdef ADD_SUB_PIPE_SAT_EN
      w_sat_in[k] = r_sat[k-1];
`endif
    end
    for (int k = 0; k < STAGES; k++) begin
      w_sum[k] = {1'b0, w_a_in[k][k*SW +: SW]} + {1'b0, w_b_in[k][k*SW +: SW]}
               + {{SW{1'b0}}, w_c_in[k]};
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*SW +: SW] = w_sum[k][SW-1:0];
    end
  end

  // Final-stage overflow and optional saturation of the assembled result.
  always_comb begin
    // Carry into the MSB recovered from the sum bit and both operand bits.
    w_cmsb = w_s_nxt[LAST][WIDTH-1] ^ w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1];
    w_ovf  = w_sum[LAST][SW] ^ w_cmsb;
`ifdef ADD_SUB_PIPE_SAT_EN
    if (w_sat_in[LAST] && w_ovf) begin
      // a positive -> 0x7F..F, a negative -> 0x80..0
      w_fin = {w_a_in[LAST][WIDTH-1], {(WIDTH-1){~w_a_in[LAST][WIDTH-1]}}};
    end else begin
      w_fin = w_s_nxt[LAST];
    end
`else
    w_fin = w_s_nxt[LAST];
`endif
  end

  // Pipeline registers: advance together when not stalled, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= {WIDTH{1'b0}};
        r_b[k] <= {WIDTH{1'b0}};
        r_s[k] <= {WIDTH{1'b0}};
      end
      r_vld <= {STAGES{1'b0}};
      r_cy  <= {STAGES{1'b0}};
      r_v   <= 1'b0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
`ifdef ADD_SUB_PIPE_SAT_EN
      r_sat <= {STAGES{1'b0}};
`endif
    end else if (!w_stall) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= w_vld_in[k];
        r_a[k]   <= w_a_in[k];
        r_b[k]   <= w_b_in[k];
        r_s[k]   <= w_s_nxt[k];
        r_cy[k]  <= w_sum[k][SW];
`ifdef ADD_SUB_PIPE_SAT_EN
        r_sat[k] <= w_sat_in[k];
`endif
      end
      // Last stage carries the final (possibly saturated) result and flags.
      r_s[LAST] <= w_fin;
      r_v       <= w_ovf;
      r_z       <= (w_fin == {WIDTH{1'b0}});
      r_n       <= w_fin[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=64, STAGES=4): directed cases
// with literal expectations, then streaming, stall, mid-stream reset and
// randomized traffic checked against a scoreboard of arithmetic results.
module tb_add_sub_pipe;
  localparam int W  = 64;
  localparam int ST = 4;
  localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MINS = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] MAXS = 64'h7FFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sat, out_valid, out_ready;
  logic [W-1:0] a, b, s;
  logic [1:0]   op;
  logic         flag_c, flag_v, flag_z, flag_n;

  add_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .cin(cin), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .s(s),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c, v, z, n;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference: plain wide arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic [1:0] iop, input logic icin, input logic isat);
    exp_t         e;
    logic [W-1:0] bp;
    logic         c0;
    logic [W:0]   full;
    bp = iop[0] ? ~ib : ib;
    c0 = (iop == 2'd0) ? 1'b0 : (iop == 2'd1) ? 1'b1 : (iop == 2'd2) ? icin : ~icin;
    full = {1'b0, ia} + {1'b0, bp} + {{W{1'b0}}, c0};
    e.s = full[W-1:0];
    e.c = full[W];
    e.v = (ia[W-1] == bp[W-1]) && (e.s[W-1] != ia[W-1]);
`ifdef ADD_SUB_PIPE_SAT_EN
    if (isat && e.v) e.s = ia[W-1] ? MINS : MAXS;
`else
    if (isat) e.s = e.s;
`endif
    e.z = (e.s == {W{1'b0}});
    e.n = e.s[W-1];
    return e;
  endfunction

  // Compare process: scoreboard push on accept, pop/compare on output transfer.
  logic         prev_stall = 1'b0;
  logic [W-1:0] p_s;
  logic [4:0]   p_f;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      chk("rst_s", s, {W{1'b0}});
      chk("rst_vld_flags", {59'd0, out_valid, flag_c, flag_v, flag_z, flag_n}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, ~(out_valid & ~out_ready)});
      if (prev_stall) begin
        chk("stall_s", s, p_s);
        chk("stall_flags", {59'd0, out_valid, flag_c, flag_v, flag_z, flag_n}, {59'd0, p_f});
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("s", s, e.s);
          chk("flags", {60'd0, flag_c, flag_v, flag_z, flag_n}, {60'd0, e.c, e.v, e.z, e.n});
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, op, cin, sat));
      prev_stall = out_valid & ~out_ready;
      p_s = s;
      p_f = {out_valid, flag_c, flag_v, flag_z, flag_n};
    end
  end

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return {W{1'b0}};
      1:       return ALL1;
      2:       return MINS;
      3:       return MAXS;
      4:       return {60'd0, 4'($urandom_range(0, 15))};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction

  task automatic set_rand();
    a   = rnd_opnd();
    b   = rnd_opnd();
    op  = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
    sat = 1'($urandom_range(0, 1));
  endtask

  // One isolated transaction on an idle pipe with literal expectations and latency.
  task automatic run_one(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [1:0] iop, input logic icin, input logic isat,
                         input logic [W-1:0] es, input logic ec, input logic ev,
                         input logic ez, input logic en);
    int lat;
    @(posedge clk); #1;
    a = ia; b = ib; op = iop; cin = icin; sat = isat; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_lat"}, 64'(lat), 64'(ST));
    chk({nm, "_s"}, s, es);
    chk({nm, "_cvzn"}, {60'd0, flag_c, flag_v, flag_z, flag_n}, {60'd0, ec, ev, ez, en});
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (ST + 4) @(posedge clk);
    #1;
    chk("drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int first, last, cnt, guard;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = {W{1'b0}}; b = {W{1'b0}}; op = 2'd0; cin = 1'b0; sat = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_one("add_wrap", ALL1, 64'd1, 2'b00, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("sub_ovf", MINS, 64'd1, 2'b01, 1'b0, 1'b0, MAXS, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef ADD_SUB_PIPE_SAT_EN
    run_one("sub_sat", MINS, 64'd1, 2'b01, 1'b0, 1'b1, MINS, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    run_one("sub_nosat", MINS, 64'd1, 2'b01, 1'b0, 1'b1, MAXS, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    run_one("sbb", 64'd5, 64'd5, 2'b11, 1'b1, 1'b0, ALL1, 1'b0, 1'b0, 1'b0, 1'b1);
    run_one("adc", 64'd5, 64'd5, 2'b10, 1'b1, 1'b0, 64'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("add_nocin", 64'd5, 64'd5, 2'b00, 1'b1, 1'b0, 64'd10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_one("sub_eq", 64'd7, 64'd7, 2'b01, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    run_one("add_pos_ovf", MAXS, 64'd1, 2'b00, 1'b0, 1'b0, MINS, 1'b0, 1'b1, 1'b0, 1'b1);

    // Ten back-to-back operations: outputs must form one unbroken run of ten.
    first = -1; last = -1; cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 10) begin set_rand(); in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      if (out_valid) begin
        cnt++;
        if (first < 0) first = i;
        last = i;
      end
    end
    chk("stream_cnt", 64'(cnt), 64'd10);
    chk("stream_span", 64'(last - first + 1), 64'd10);
    chk("stream_first", 64'(first), 64'(ST - 1));
    drain();

    // Fill with out_ready low, hold five stalled cycles, then release.
    out_ready = 1'b0;
    guard = 0;
    set_rand(); in_valid = 1'b1;
    @(posedge clk); #1;
    while (!out_valid && guard < 20) begin
      set_rand();
      @(posedge clk); #1;
      guard++;
    end
    chk("fill_reached", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      set_rand();
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin set_rand(); @(posedge clk); #1; end
    drain();

    // Reset for one cycle in the middle of a stream.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin set_rand(); in_valid = 1'b1; @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_s", s, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin set_rand(); in_valid = 1'b1; @(posedge clk); #1; end
    drain();

    // Random traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      set_rand();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
